// File: rtl/sha256_round_core.sv
// Iterative SHA-256 compression: one round per clock, 66 cycles per block.
// Optional SHA256_FEEDFORWARD_EN adds the chaining value into the digest.
module sha256_round_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic [255:0] chain_in,
  output logic [5:0]   k_addr,
  input  logic [31:0]  k_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest_out
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  state_t      state, state_nx;
  logic [5:0]  t;
  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] w [16];
  logic [31:0] t1, t2, w_new;
`ifdef SHA256_FEEDFORWARD_EN
  logic [31:0] hs [8];
`endif

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  always_comb begin
    t1    = h + big_sig1(e) + ((e & f) ^ (~e & g)) + k_in + w[0];
    t2    = big_sig0(a) + ((a & b) ^ (a & c) ^ (b & c));
    w_new = small_sig1(w[14]) + w[9] + small_sig0(w[1]) + w[0];
  end

  // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: state_nx gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ROUND;
      ROUND:   if (t == 6'd63) state_nx = FINAL;
      FINAL:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // t wraps 63->0 on the last round, so k_addr is back at 0 during FINAL.
  always_comb begin
    busy   = (state != IDLE);
    k_addr = t;
  end

  // NOTE: the W window is a bank of flops, not a RAM, so it can take the async clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t          <= '0;
      done       <= 1'b0;
      digest_out <= '0;
      {a, b, c, d, e, f, g, h} <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
`ifdef SHA256_FEEDFORWARD_EN
      for (int i = 0; i < 8; i++) hs[i] <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            t <= '0;
            {a, b, c, d, e, f, g, h} <= chain_in;
            for (int i = 0; i < 16; i++) w[i] <= block_in[511 - 32*i -: 32];
`ifdef SHA256_FEEDFORWARD_EN
            for (int i = 0; i < 8; i++) hs[i] <= chain_in[255 - 32*i -: 32];
`endif
          end
        end
        ROUND: begin
          t <= t + 6'd1;
          h <= g;
          g <= f;
          f <= e;
          e <= d + t1;
          d <= c;
          c <= b;
          b <= a;
          a <= t1 + t2;
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= w_new;
        end
        FINAL: begin
          done <= 1'b1;
`ifdef SHA256_FEEDFORWARD_EN
          digest_out <= {a + hs[0], b + hs[1], c + hs[2], d + hs[3],
                         e + hs[4], f + hs[5], g + hs[6], h + hs[7]};
`else
          digest_out <= {a, b, c, d, e, f, g, h};
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_core.sv
// Self-checking bench for sha256_round_core against a full-schedule SHA-256 model.
// Expected digests follow the SHA256_FEEDFORWARD_EN setting of the build.
module tb_sha256_round_core;

  localparam logic [255:0] IV        = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};

  logic         clk, rst_n, start;
  logic [511:0] block_in;
  logic [255:0] chain_in;
  logic [5:0]   k_addr;
  logic [31:0]  k_in;
  logic         busy, done;
  logic [255:0] digest_out;

  logic [31:0] k_rom [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  assign k_in = k_rom[k_addr];

  sha256_round_core dut (
    .clk(clk), .rst_n(rst_n), .start(start), .block_in(block_in), .chain_in(chain_in),
    .k_addr(k_addr), .k_in(k_in), .busy(busy), .done(done), .digest_out(digest_out));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  bit clk_en = 0;

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] wordwise_add(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = x[255 - 32*i -: 32] + y[255 - 32*i -: 32];
    return r;
  endfunction

  // Raw working variables after 64 rounds, using the full 64-entry schedule.
  function automatic logic [255:0] sha_model(input logic [511:0] blk, input logic [255:0] chn);
    logic [31:0] wv [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, x1, x2;
    for (int i = 0; i < 16; i++) wv[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rr(wv[i-15], 7) ^ rr(wv[i-15], 18) ^ (wv[i-15] >> 3);
      s1 = rr(wv[i-2], 17) ^ rr(wv[i-2], 19) ^ (wv[i-2] >> 10);
      wv[i] = s1 + wv[i-7] + s0 + wv[i-16];
    end
    for (int i = 0; i < 8; i++) v[i] = chn[255 - 32*i -: 32];
    for (int r = 0; r < 64; r++) begin
      x1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
           + k_rom[r] + wv[r];
      x2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + x1;
      v[0] = x1 + x2;
    end
    return {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
  endfunction

  function automatic logic [255:0] expect_dig(input logic [511:0] blk, input logic [255:0] chn);
`ifdef SHA256_FEEDFORWARD_EN
    return wordwise_add(sha_model(blk, chn), chn);
`else
    return sha_model(blk, chn);
`endif
  endfunction

  // Maps the DUT output to the standard compression result for an IV-chained block.
  function automatic logic [255:0] to_std(input logic [255:0] dig);
`ifdef SHA256_FEEDFORWARD_EN
    return dig;
`else
    return wordwise_add(dig, IV);
`endif
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [511:0] blk, input logic [255:0] chn);
    @(negedge clk);
    block_in = blk;
    chain_in = chn;
    start    = 1'b1;
  endtask

  // Next posedge is the accept edge E0; follows the hash until done or budget expiry.
  task automatic track(input bit check_k, input bit noise, input bit chain_next,
                       input logic [511:0] nblk, input logic [255:0] nchn,
                       output int lat, output int done_at);
    logic [255:0] held;
    held    = digest_out;
    lat     = -1;
    done_at = -1;
    @(posedge clk); #1;
    start    = 1'b0;
    block_in = rand512();
    chain_in = rand256();
    check("busy_after_accept", 256'(busy), 256'(1'b1));
    if (check_k) check("k_addr_r0", 256'(k_addr), 256'd0);
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      if (check_k && n <= 63) check("k_addr_step", 256'(k_addr), 256'(n));
      if (check_k && n == 64) check("k_addr_final", 256'(k_addr), 256'd0);
      if (n == 10) check("digest_hold", digest_out, held);
      if (noise) begin
        if (n == 5 || n == 40) begin
          start    = 1'b1;
          block_in = rand512();
          chain_in = rand256();
        end else begin
          start = 1'b0;
        end
      end
      if (done) begin
        lat     = n;
        done_at = cyc;
        check("busy_in_done", 256'(busy), 256'd0);
        if (chain_next) begin
          block_in = nblk;
          chain_in = nchn;
          start    = 1'b1;
        end else begin
          start = 1'b0;
        end
        break;
      end
    end
    check("latency", 256'(lat), 256'd65);
  endtask

  initial begin
    int lat, t_first, t_second, dc0, dc1;
    logic [511:0] blk;
    logic [255:0] chn;

    rst_n    = 1'b0;
    start    = 1'b0;
    block_in = rand512();
    chain_in = rand256();
    #3;
    check("rst_busy",   256'(busy),   256'd0);
    check("rst_done",   256'(done),   256'd0);
    check("rst_k_addr", 256'(k_addr), 256'd0);
    check("rst_digest", digest_out,   256'd0);

    #5 clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1 dc0 = done_cnt;

    // "abc" with ignored start pulses, then a second block accepted in the done cycle.
    issue(ABC_BLK, IV);
    track(1'b1, 1'b1, 1'b1, EMPTY_BLK, IV, lat, t_first);
    check("abc_digest", to_std(digest_out), ABC_DIG);
    check("abc_model",  digest_out, expect_dig(ABC_BLK, IV));

    track(1'b0, 1'b0, 1'b0, '0, '0, lat, t_second);
    check("abc_single_done", 256'(done_cnt - dc0), 256'd1);
    check("empty_digest", to_std(digest_out), EMPTY_DIG);
    check("b2b_done_gap", 256'(t_second - t_first), 256'd66);

    // Reset during round 30 aborts the hash cleanly.
    repeat (2) @(negedge clk);
    #1 dc1 = done_cnt;
    issue(ABC_BLK, IV);
    @(posedge clk); #1;
    start    = 1'b0;
    block_in = rand512();
    repeat (30) @(posedge clk);
    #1;
    check("k_addr_r30", 256'(k_addr), 256'd30);
    rst_n = 1'b0;
    #1;
    check("midrst_busy",   256'(busy),   256'd0);
    check("midrst_k_addr", 256'(k_addr), 256'd0);
    check("midrst_digest", digest_out,   256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("midrst_no_done", 256'(done_cnt - dc1), 256'd0);
    issue(EMPTY_BLK, IV);
    track(1'b0, 1'b0, 1'b0, '0, '0, lat, t_second);
    check("midrst_empty_digest", to_std(digest_out), EMPTY_DIG);

    // Random blocks and chaining values against the model.
    for (int i = 0; i < 5; i++) begin
      blk = rand512();
      chn = rand256();
      issue(blk, chn);
      track(1'b0, 1'b0, 1'b0, '0, '0, lat, t_second);
      check("rand_digest", digest_out, expect_dig(blk, chn));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha256_round_core.md
Name: sha256_round_core

Overview:
- Iterative SHA-256 compression engine for the hashing datapath.
- Accepts one 512-bit message block and a 256-bit chaining value. Runs 64 rounds at one round per clock.
- Drives the 6-bit round index to the round-constant lookup table and consumes its combinational 32-bit K word in the same cycle.
- Produces the 256-bit digest of the block; the upstream block/nonce sequencer feeds it and the result is chained back or compared downstream.

Parameters:
- None. Widths are fixed by SHA-256: 512-bit block, 256-bit state, 32-bit words, 64 rounds.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request to hash; sampled only while idle
- block_in  input  512  message block; W0 = block_in[511:480], W15 = block_in[31:0]
- chain_in  input  256  initial H0..H7; H0 = chain_in[255:224], H7 = chain_in[31:0]
- k_addr  output  6  round index presented to the K LUT
- k_in  input  32  K[k_addr], combinational return from the LUT
- busy  output  1  high from the accept edge until the digest is latched
- done  output  1  one-cycle pulse; digest_out is valid from this cycle on
- digest_out  output  256  result, same word order as chain_in

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: state=IDLE, round counter=0, k_addr=0, busy=0, done=0, digest_out=0. Working registers a..h, saved H, and the W window all clear to 0.
- FSM states: IDLE, ROUND, FINAL.
- IDLE:
  - start=1 at an edge: latch chain_in into a..h and into the saved H0..H7.
  - Load the 16-word W window: w[i] = W_i.
  - Set counter t=0 and go to ROUND.
  - start=0: stay in IDLE.
- ROUND (64 cycles, t = 0..63):
  - k_addr = t, driven from the registered counter with no combinational path from start.
  - T1 = h + Σ1(e) + Ch(e,f,g) + k_in + w[0].
  - T2 = Σ0(a) + Maj(a,b,c).
  - All adds are modulo 2^32; carries are discarded.
  - Σ0 = ROTR2^ROTR13^ROTR22.
  - Σ1 = ROTR6^ROTR11^ROTR25.
  - σ0 = ROTR7^ROTR18^SHR3.
  - σ1 = ROTR17^ROTR19^SHR10.
  - Working-register update: h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
  - Window update: shift left so w[i]←w[i+1]. New w[15] = σ1(w[14]) + w[9] + σ0(w[1]) + w[0].
  - The window update is uniform for every t. Words computed for t ≥ 48 are never consumed.
  - At t=63, go to FINAL. Otherwise t←t+1.
- FINAL (1 cycle):
  - Latch digest_out as defined by the optional feature.
  - Assert done for exactly this following cycle.
  - Return to IDLE; k_addr returns to 0.
- Latency: the edge sampling start is E0. Rounds occur at E1..E64. digest_out and done are registered at E65. done is high between E65 and E66.
- busy: high after E0 through E65, i.e. busy = (state != IDLE).
- start while busy: ignored, with no effect on the running hash.
- Back-to-back operation: start is sampled again at E66 (the cycle done is high). Throughput is one block per 66 cycles.
- Hold: digest_out holds its value until the next FINAL. It does not change on a new start.
- Input stability: block_in and chain_in are used only at E0 and may change afterwards.
- Reset mid-operation: immediately returns to the reset values. No done pulse, no partial digest.

Optional Feature:
- Macro: SHA256_FEEDFORWARD_EN.
- Defined: digest_out word i = H_i + working_i (mod 2^32), i.e. the standard compression output.
- Not defined: digest_out = raw {a,b,c,d,e,f,g,h} after round 63, with the addition left to the downstream consumer. The saved-H registers and their adders are removed.
- Latency and handshake are identical in both builds.

Test Plan:
- Reset: apply rst_n=0 with no clock running -> busy=0, done=0, digest_out=0, k_addr=0 immediately.
- "abc" test, feed-forward on:
  - Stimulus: block_in = 61626380_00000000×14_00000018; chain_in = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19 (standard IV).
  - Required: done exactly 65 edges after the start edge, k_addr stepping 0..63 across the rounds, digest_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty-message test, feed-forward on:
  - Stimulus: block_in = 80000000 followed by 15 zero words; IV as above.
  - Required: digest_out = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Feature off: "abc" vector -> wordwise (digest_out + IV) mod 2^32 equals the "abc" digest above.
- start pulses while busy:
  - Pulse start at rounds 5 and 40 with a different block -> the "abc" result is unchanged and exactly one done is seen.
  - Then assert start in the done cycle -> the second hash is accepted and its done arrives 66 cycles after the first.
- Reset mid-operation: drop rst_n at round 30, release, then restart with the empty message -> no done before the restart, and the correct empty-message digest afterwards.
